// File: rtl/data_mem_responder_if.sv
// Request/response bus between a load/store initiator and data_mem_responder.
// The byte_access lane exists only when DMEM_BYTE_ACCESS_EN is defined.
interface data_mem_responder_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        ack;
    logic        err;
`ifdef DMEM_BYTE_ACCESS_EN
    logic        byte_access;

    modport master (output req, we, addr, wd, byte_access, input rd, ack, err);
    modport slave  (input req, we, addr, wd, byte_access, output rd, ack, err);
`else
    modport master (output req, we, addr, wd, input rd, ack, err);
    modport slave  (input req, we, addr, wd, output rd, ack, err);
`endif
endinterface

// File: rtl/data_mem_responder.sv
// Single-outstanding data memory with programmable wait states and error checking.
// Define DMEM_BYTE_ACCESS_EN to add byte loads/stores (LDRB/STRB) via bus.byte_access.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    data_mem_responder_if.slave  bus
);
    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state_reg;
    logic [3:0]  cnt_reg;
    logic        we_reg;
    logic        byte_reg;
    logic        ack_reg;
    logic        err_reg;
    logic [31:0] addr_reg;
    logic [31:0] wd_reg;
    logic [31:0] rdata_reg;
    logic [31:0] mem [DEPTH_WORDS];

    logic [31:0]      cur_addr;
    logic             cur_byte;
    logic             cur_err;
    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] wr_idx;
    logic [3:0]       lane_en;
    logic [31:0]      wdata;
    logic [31:0]      rd_shift;
    logic [31:0]      rd_val;

    // In IDLE the request is still on the bus; afterwards use the latched copy,
    // so error and read index are right even when WAIT_CYCLES is zero.
    assign cur_addr = (state_reg == IDLE) ? bus.addr : addr_reg;
`ifdef DMEM_BYTE_ACCESS_EN
    assign cur_byte = (state_reg == IDLE) ? bus.byte_access : byte_reg;
`else
    assign cur_byte = 1'b0;
`endif

    assign cur_err = ({2'b00, cur_addr[31:2]} >= 32'(DEPTH_WORDS)) ||
                     (!cur_byte && (cur_addr[1:0] != 2'b00));
    assign rd_idx  = cur_addr[IDX_W+1:2];
    assign wr_idx  = addr_reg[IDX_W+1:2];
    assign lane_en = byte_reg ? (4'b0001 << addr_reg[1:0]) : 4'b1111;
    assign wdata   = byte_reg ? {4{wd_reg[7:0]}} : wd_reg;

    // Storage is never reset; the write lands on the edge that closes RESP.
    always_ff @(posedge clk) begin
        rdata_reg <= mem[rd_idx];
        if (!rst && state_reg == RESP && we_reg && !err_reg) begin
            for (int i = 0; i < 4; i++) begin
                if (lane_en[i]) begin
                    mem[wr_idx][i*8 +: 8] <= wdata[i*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= 4'd0;
            ack_reg   <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    ack_reg <= 1'b0;
                    err_reg <= 1'b0;
                    if (bus.req) begin
                        we_reg   <= bus.we;
                        addr_reg <= bus.addr;
                        wd_reg   <= bus.wd;
                        byte_reg <= cur_byte;
                        cnt_reg  <= 4'(WAIT_CYCLES);
                        if (WAIT_CYCLES == 0) begin
                            state_reg <= RESP;
                            ack_reg   <= 1'b1;
                            err_reg   <= cur_err;
                        end else begin
                            state_reg <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    cnt_reg <= cnt_reg - 4'd1;
                    if (cnt_reg == 4'd1) begin
                        state_reg <= RESP;
                        ack_reg   <= 1'b1;
                        err_reg   <= cur_err;
                    end
                end
                RESP: begin
                    state_reg <= IDLE;
                    ack_reg   <= 1'b0;
                    err_reg   <= 1'b0;
                end
                default: begin
                    state_reg <= IDLE;
                    ack_reg   <= 1'b0;
                    err_reg   <= 1'b0;
                end
            endcase
        end
    end

    assign rd_shift = rdata_reg >> {addr_reg[1:0], 3'b000};

    always_comb begin
        rd_val = 32'h0;
        if (ack_reg && !err_reg && !we_reg) begin
            rd_val = byte_reg ? {24'h0, rd_shift[7:0]} : rdata_reg;
        end
    end

    assign bus.rd  = rd_val;
    assign bus.ack = ack_reg;
    assign bus.err = err_reg;
endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized and directed checks of data_mem_responder against a word-array model.
// Second instance runs with zero wait states for back-to-back behaviour.
module tb_data_mem_responder;
    localparam int DEPTH = 64;
    localparam int WAITS = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    data_mem_responder_if bus();
    data_mem_responder_if bus0();

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAITS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    data_mem_responder #(.DEPTH_WORDS(16), .WAIT_CYCLES(0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] model_mem   [DEPTH];
    bit          model_valid [DEPTH];
    logic        byte_sel = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one request on the WAIT_CYCLES=2 port, scramble inputs after sampling,
    // and report the ack latency in cycles (0 if it never came).
    task automatic run_txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                           output logic [31:0] rd_o, output logic err_o, output int lat);
        @(negedge clk);
        bus.req  = 1'b1;
        bus.we   = w;
        bus.addr = a;
        bus.wd   = d;
`ifdef DMEM_BYTE_ACCESS_EN
        bus.byte_access = byte_sel;
`endif
        @(posedge clk);
        #1;
        bus.req  = 1'b0;
        bus.we   = 1'($urandom);
        bus.addr = $urandom;
        bus.wd   = $urandom;
`ifdef DMEM_BYTE_ACCESS_EN
        bus.byte_access = 1'($urandom);
`endif
        lat   = 0;
        rd_o  = 32'h0;
        err_o = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (bus.ack) begin
                lat   = k;
                rd_o  = bus.rd;
                err_o = bus.err;
                break;
            end
        end
        @(negedge clk);
        check_val("ack_one_cycle", {31'b0, bus.ack}, 32'h0);
    endtask

    // Word-access transaction checked against the model.
    task automatic txn_check(input string tag, input logic w, input logic [31:0] a, input logic [31:0] d);
        logic [31:0] got_rd;
        logic        got_err;
        int          lat;
        logic        exp_err;
        int          idx;
        idx     = int'(a >> 2);
        exp_err = (a >> 2) >= 32'(DEPTH) || (a % 4) != 0;
        run_txn(w, a, d, got_rd, got_err, lat);
        check_val({tag, "_lat"}, 32'(lat), 32'(WAITS + 1));
        check_val({tag, "_err"}, {31'b0, got_err}, {31'b0, exp_err});
        if (w || exp_err) begin
            check_val({tag, "_rd0"}, got_rd, 32'h0);
        end else if (model_valid[idx]) begin
            check_val({tag, "_rd"}, got_rd, model_mem[idx]);
        end
        if (w && !exp_err) begin
            model_mem[idx]   = d;
            model_valid[idx] = 1'b1;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int          acks;
        logic [5:0]  pattern;
        logic [31:0] a;
        logic [31:0] got_rd;
        logic        got_err;
        int          lat;

        for (int i = 0; i < DEPTH; i++) model_valid[i] = 1'b0;
        bus.req = 1'b1; bus.we = 1'b1; bus.addr = 32'h0; bus.wd = 32'h5555_5555;
        bus0.req = 1'b1; bus0.we = 1'b0; bus0.addr = 32'h0; bus0.wd = 32'h0;
`ifdef DMEM_BYTE_ACCESS_EN
        bus.byte_access = 1'b0;
        bus0.byte_access = 1'b0;
`endif
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_val("rst_ack", {31'b0, bus.ack}, 32'h0);
        check_val("rst_err", {31'b0, bus.err}, 32'h0);
        check_val("rst_rd", bus.rd, 32'h0);
        check_val("rst_ack0", {31'b0, bus0.ack}, 32'h0);
        rst = 1'b0;
        bus.req = 1'b0;
        bus0.req = 1'b0;
        acks = 0;
        repeat (6) begin
            @(negedge clk);
            acks += int'(bus.ack) + int'(bus0.ack);
        end
        check_val("req_in_rst_ignored", 32'(acks), 32'h0);

        // Basic store/load, misaligned load, out-of-range store
        txn_check("st_10", 1'b1, 32'h10, 32'hDEADBEEF);
        txn_check("ld_10", 1'b0, 32'h10, 32'h0);
        txn_check("ld_12_misal", 1'b0, 32'h12, 32'h0);
        txn_check("ld_10_again", 1'b0, 32'h10, 32'h0);
        txn_check("st_00", 1'b1, 32'h0, 32'h0BAD_F00D);
        txn_check("st_100_oor", 1'b1, 32'h100, 32'hFFFF_FFFF);
        txn_check("ld_00_after_oor", 1'b0, 32'h0, 32'h0);
        txn_check("ld_fc_last", 1'b1, 32'hFC, 32'h1357_9BDF);
        txn_check("ld_fc_last", 1'b0, 32'hFC, 32'h0);

        // Reset during WAIT must abort the store
        txn_check("st_20", 1'b1, 32'h20, 32'hCAFEF00D);
        @(negedge clk);
        bus.req = 1'b1; bus.we = 1'b1; bus.addr = 32'h20; bus.wd = 32'h12345678;
        @(posedge clk);
        #1;
        bus.req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        acks = 0;
        repeat (6) begin
            @(negedge clk);
            acks += int'(bus.ack);
        end
        check_val("abort_no_ack", 32'(acks), 32'h0);
        txn_check("ld_20_after_abort", 1'b0, 32'h20, 32'h0);

        // Preload words 0..7 then random traffic
        for (int i = 0; i < 8; i++) txn_check("pre", 1'b1, 32'(i * 4), $urandom);
        for (int t = 0; t < 40; t++) begin
            case ($urandom_range(0, 3))
                0: a = 32'($urandom_range(0, 7) * 4) | 32'($urandom_range(1, 3));
                1: a = 32'($urandom_range(DEPTH, 4000) * 4);
                default: a = 32'($urandom_range(0, 7) * 4);
            endcase
            txn_check("rnd", 1'($urandom), a, $urandom);
        end

`ifdef DMEM_BYTE_ACCESS_EN
        txn_check("b_st_10", 1'b1, 32'h10, 32'hDEADBEEF);
        byte_sel = 1'b1;
        run_txn(1'b1, 32'h11, 32'h0000_00AA, got_rd, got_err, lat);
        check_val("b_st_11_err", {31'b0, got_err}, 32'h0);
        byte_sel = 1'b0;
        run_txn(1'b0, 32'h10, 32'h0, got_rd, got_err, lat);
        check_val("b_ld_10_word", got_rd, 32'hDEADAAEF);
        byte_sel = 1'b1;
        run_txn(1'b0, 32'h13, 32'h0, got_rd, got_err, lat);
        check_val("b_ld_13", got_rd, 32'h0000_00DE);
        check_val("b_ld_13_err", {31'b0, got_err}, 32'h0);
        byte_sel = 1'b0;
        model_mem[4] = 32'hDEADAAEF;
`endif

        // Zero wait states: req held for 6 cycles gives acks on alternate cycles
        @(negedge clk);
        bus0.req = 1'b1; bus0.we = 1'b0; bus0.addr = 32'h4;
        pattern = 6'b0;
        acks = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            pattern[i] = bus0.ack;
            if (bus0.ack) acks += int'(bus0.err) * 100 + 1;
        end
        bus0.req = 1'b0;
        repeat (3) begin
            @(negedge clk);
            acks += int'(bus0.ack);
        end
        check_val("w0_ack_pattern", {26'b0, pattern}, {26'b0, 6'b010101});
        check_val("w0_ack_count", 32'(acks), 32'd3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 64: number of 32-bit words stored; legal range 1..1024.
REQ-002 Parameter WAIT_CYCLES, default 2: wait states inserted before each response; legal range 0..15.
REQ-003 clk  input  1: single clock; all state updates on rising edge.
REQ-004 rst  input  1: reset, synchronous, active-high.
REQ-005 req  input  1: initiator request; held high until ack is seen.
REQ-006 we  input  1: 1 = store, 0 = load; qualified by req.
REQ-007 addr  input  32: byte address from processor ALU result.
REQ-008 wd  input  32: store data.
REQ-009 byte  input  1: 1 = byte access (LDRB/STRB), 0 = word access; present only with DMEM_BYTE_ACCESS_EN.
REQ-010 rd  output  32: load data; valid only while ack=1, else 32'h0.
REQ-011 ack  output  1: one-cycle response strobe.
REQ-012 err  output  1: error flag, valid only while ack=1, else 0.

Function
REQ-013 FSM states IDLE, WAIT, RESP; the block SHALL serve exactly one transaction at a time.
REQ-014 IDLE: on edge with req=1, the block SHALL latch we, addr, wd, byte, load wait counter with WAIT_CYCLES, and go to WAIT (or directly to RESP if WAIT_CYCLES=0).
REQ-015 WAIT: counter decrements each cycle; on the edge where counter equals 1, the block SHALL go to RESP.
REQ-016 RESP: ack=1 for exactly one cycle, then IDLE unconditionally.
REQ-017 Latency: ack SHALL assert WAIT_CYCLES+1 cycles after the edge that samples req.
REQ-018 Word index = latched addr[31:2]; index >= DEPTH_WORDS SHALL give err=1, rd=0, no write.
REQ-019 Word access with addr[1:0] != 0 SHALL give err=1, rd=0, no write.
REQ-020 Store without error SHALL update the array on the RESP-cycle edge; rd SHALL be 0 during a store ack.
REQ-021 Load without error SHALL drive rd with the addressed word during the ack cycle.
REQ-022 Inputs changing after the sampling edge SHALL not affect the transaction in flight; req dropping during WAIT SHALL not cancel it (ack still issued).
REQ-023 req still high in the cycle after ack SHALL be treated as a new request (sampled in IDLE); minimum spacing between acks is WAIT_CYCLES+2 cycles.
REQ-024 Array contents SHALL be undefined after power-up and SHALL not be cleared by rst.

Reset
REQ-025 rst=1 at an edge SHALL force IDLE, counter=0, ack=0, err=0, rd=0 regardless of state.
REQ-026 rst during WAIT or RESP SHALL abort the transaction; an aborted store SHALL not write the array.
REQ-027 req sampled in the same cycle as rst=1 SHALL be ignored.

Configuration
REQ-028 Macro DMEM_BYTE_ACCESS_EN defined: byte port present; byte load returns the addressed byte (addr[1:0]=0 is bits 7:0, little-endian) zero-extended; byte store writes only that byte lane; byte accesses never raise the alignment error.
REQ-029 Macro undefined: byte port absent; every access is a word access; REQ-019 applies to all accesses.

Verification
REQ-030 WAIT_CYCLES=2; store addr=0x10, wd=0xDEADBEEF -> ack at 3rd edge after sampling, err=0; then load 0x10 -> rd=0xDEADBEEF on ack.
REQ-031 Load addr=0x12, word access -> ack with err=1, rd=0; subsequent load 0x10 still returns 0xDEADBEEF.
REQ-032 DEPTH_WORDS=64; store addr=0x100 -> err=1; the array is unchanged (spot-check word 0 against its prior value).
REQ-033 rst pulsed during WAIT of store 0x20 <- 0x12345678 -> no ack, IDLE next cycle; load 0x20 returns prior contents.
REQ-034 DMEM_BYTE_ACCESS_EN: word 0x10=0xDEADBEEF, byte store addr=0x11 wd=0x000000AA -> word 0x10 reads 0xDEADAAEF; byte load 0x13 -> rd=0x000000DE.
REQ-035 WAIT_CYCLES=0 with req held high for 6 cycles -> acks on alternate cycles (3 acks).
